sc_width_conv_fifo: RTL and testbench

- Single-clock FIFO with independent, integer-ratio input and output widths. Packs narrow writes into wide reads, or unpacks wide writes into narrow reads.
- Adds selectable show-ahead, programmable almost-full/almost-empty flags, a synchronous flush, and overflow/underflow error pulses.
- Buffers data between same-clock producer/consumer stages of differing bus widths in the camera datapath, e.g. 8-bit sensor bytes to 16/32-bit USB3 words.

---
 rtl/sc_width_conv_fifo.sv | 137 +++++++++++++
 tb/tb_sc_width_conv_fifo.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_width_conv_fifo.sv
// Single-clock FIFO with integer-ratio input/output widths: packs narrow writes into wide
// reads or unpacks wide writes into narrow reads. Optional show-ahead, level flags, error pulses.
module sc_width_conv_fifo #(
   parameter int DATA_IN_W  = 8,
   parameter int DATA_OUT_W = 16,
   parameter int ADDR_W     = 10,
   parameter int SHOWAHEAD  = 0,
   parameter int MSB_FIRST  = 0,
   parameter int AF_LEVEL   = 2**ADDR_W-16,
   parameter int AE_LEVEL   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sclr,
   input  logic                  wrreq,
   input  logic [DATA_IN_W-1:0]  data_in,
   output logic                  wrfull,
   output logic                  wr_almost_full,
   output logic [ADDR_W:0]       wrusedw,
   input  logic                  rdreq,
   output logic [DATA_OUT_W-1:0] data_out,
   output logic                  rdempty,
   output logic                  rd_almost_empty,
   output logic [ADDR_W:0]       rdusedw,
   output logic                  overflow,
   output logic                  underflow
);
   localparam int U     = (DATA_IN_W < DATA_OUT_W) ? DATA_IN_W : DATA_OUT_W;
   localparam int WI    = DATA_IN_W / U;
   localparam int RO    = DATA_OUT_W / U;
   localparam int DEPTH = 2**ADDR_W;

   localparam logic [ADDR_W:0]   C_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   C_WI    = (ADDR_W+1)'(WI);
   localparam logic [ADDR_W:0]   C_RO    = (ADDR_W+1)'(RO);
   localparam logic [ADDR_W:0]   C_AF    = (ADDR_W+1)'(AF_LEVEL);
   localparam logic [ADDR_W:0]   C_AE    = (ADDR_W+1)'(AE_LEVEL);
   localparam logic [ADDR_W-1:0] C_WI_P  = ADDR_W'(WI);
   localparam logic [ADDR_W-1:0] C_RO_P  = ADDR_W'(RO);

   // Unit-granular storage; any WI/RO ratio wraps cleanly at a power-of-two depth.
   logic [U-1:0]          r_mem [DEPTH];
   logic [ADDR_W-1:0]     r_wr_ptr;
   logic [ADDR_W-1:0]     r_rd_ptr;
   logic [ADDR_W:0]       r_used;

   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic                  w_load;
   logic [ADDR_W-1:0]     w_wr_ptr_nxt;
   logic [ADDR_W-1:0]     w_rd_ptr_nxt;
   logic [ADDR_W-1:0]     w_head_ptr;
   logic [ADDR_W:0]       w_used_nxt;
   logic [WI-1:0][U-1:0]  w_in_u;
   logic [DATA_OUT_W-1:0] w_head;

   assign w_wr_acc = wrreq & ~wrfull  & ~sclr;
   assign w_rd_acc = rdreq & ~rdempty & ~sclr;

   assign w_wr_ptr_nxt = sclr ? '0 : (w_wr_acc ? r_wr_ptr + C_WI_P : r_wr_ptr);
   assign w_rd_ptr_nxt = sclr ? '0 : (w_rd_acc ? r_rd_ptr + C_RO_P : r_rd_ptr);
   assign w_used_nxt   = sclr ? '0 :
                         r_used + (w_wr_acc ? C_WI : '0) - (w_rd_acc ? C_RO : '0);

   // Input word split into units, index 0 = earliest.
   for (genvar j = 0; j < WI; j++) begin : g_in
      localparam int SRC = (MSB_FIRST != 0) ? WI-1-j : j;
      assign w_in_u[j] = data_in[SRC*U +: U];
   end

   // Show-ahead loads the post-update head word, so units landing this edge are bypassed in.
   assign w_head_ptr = (SHOWAHEAD != 0) ? w_rd_ptr_nxt : r_rd_ptr;
   assign w_load     = (SHOWAHEAD != 0) ? (~sclr & (w_used_nxt >= C_RO)) : w_rd_acc;

   always_comb begin : p_head
      logic [ADDR_W-1:0] a;
      logic [U-1:0]      u;
      a      = '0;
      u      = '0;
      w_head = '0;
      for (int k = 0; k < RO; k++) begin
         a = w_head_ptr + ADDR_W'(k);
         u = r_mem[a];
         for (int j = 0; j < WI; j++)
            if ((SHOWAHEAD != 0) && w_wr_acc && (a == r_wr_ptr + ADDR_W'(j)))
               u = w_in_u[j];
         if (MSB_FIRST != 0) w_head[(RO-1-k)*U +: U] = u;
         else                w_head[k*U +: U]        = u;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_acc)
         for (int j = 0; j < WI; j++)
            r_mem[r_wr_ptr + ADDR_W'(j)] <= w_in_u[j];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr        <= '0;
         r_rd_ptr        <= '0;
         r_used          <= '0;
         wrfull          <= 1'b0;
         wr_almost_full  <= 1'b0;
         wrusedw         <= '0;
         rdempty         <= 1'b1;
         rd_almost_empty <= 1'b1;
         rdusedw         <= '0;
         data_out        <= '0;
         overflow        <= 1'b0;
         underflow       <= 1'b0;
      end else begin
         r_wr_ptr  <= w_wr_ptr_nxt;
         r_rd_ptr  <= w_rd_ptr_nxt;
         r_used    <= w_used_nxt;
         overflow  <= wrreq & wrfull  & ~sclr;
         underflow <= rdreq & rdempty & ~sclr;
         if (w_load)
            data_out <= w_head;
         if (sclr) begin
            wrfull          <= 1'b0;
            wr_almost_full  <= 1'b0;
            wrusedw         <= '0;
            rdempty         <= 1'b1;
            rd_almost_empty <= 1'b1;
            rdusedw         <= '0;
         end else begin
            wrfull          <= (C_DEPTH - w_used_nxt) < C_WI;
            wr_almost_full  <= w_used_nxt >= C_AF;
            wrusedw         <= w_used_nxt / C_WI;
            rdempty         <= w_used_nxt < C_RO;
            rd_almost_empty <= w_used_nxt <= C_AE;
            rdusedw         <= w_used_nxt / C_RO;
         end
      end
   end
endmodule

// File: tb/tb_sc_width_conv_fifo.sv
// Directed bench: 8->16 packing (table-driven), 32->8 show-ahead unpacking, 8->8 full-boundary
// concurrency, flush and async reset.
module tb_sc_width_conv_fifo;
   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A: 8 -> 16, normal read, 16 units
   logic        a_clr, a_wr, a_rd;
   logic [7:0]  a_din;
   logic [15:0] a_dout;
   logic        a_full, a_af, a_empty, a_ae, a_ovf, a_unf;
   logic [4:0]  a_wru, a_rdu;
   // B: 32 -> 8, show-ahead
   logic        b_clr, b_wr, b_rd;
   logic [31:0] b_din;
   logic [7:0]  b_dout;
   logic        b_full, b_af, b_empty, b_ae, b_ovf, b_unf;
   logic [4:0]  b_wru, b_rdu;
   // C: 8 -> 8, normal read
   logic        c_clr, c_wr, c_rd;
   logic [7:0]  c_din;
   logic [7:0]  c_dout;
   logic        c_full, c_af, c_empty, c_ae, c_ovf, c_unf;
   logic [4:0]  c_wru, c_rdu;

   sc_width_conv_fifo #(.DATA_IN_W(8), .DATA_OUT_W(16), .ADDR_W(4), .SHOWAHEAD(0),
                        .MSB_FIRST(0), .AF_LEVEL(12), .AE_LEVEL(2)) u_a (
      .clk(clk), .rst_n(rst_n), .sclr(a_clr), .wrreq(a_wr), .data_in(a_din),
      .wrfull(a_full), .wr_almost_full(a_af), .wrusedw(a_wru), .rdreq(a_rd),
      .data_out(a_dout), .rdempty(a_empty), .rd_almost_empty(a_ae), .rdusedw(a_rdu),
      .overflow(a_ovf), .underflow(a_unf));

   sc_width_conv_fifo #(.DATA_IN_W(32), .DATA_OUT_W(8), .ADDR_W(4), .SHOWAHEAD(1),
                        .MSB_FIRST(0), .AF_LEVEL(12), .AE_LEVEL(2)) u_b (
      .clk(clk), .rst_n(rst_n), .sclr(b_clr), .wrreq(b_wr), .data_in(b_din),
      .wrfull(b_full), .wr_almost_full(b_af), .wrusedw(b_wru), .rdreq(b_rd),
      .data_out(b_dout), .rdempty(b_empty), .rd_almost_empty(b_ae), .rdusedw(b_rdu),
      .overflow(b_ovf), .underflow(b_unf));

   sc_width_conv_fifo #(.DATA_IN_W(8), .DATA_OUT_W(8), .ADDR_W(4), .SHOWAHEAD(0),
                        .MSB_FIRST(0), .AF_LEVEL(12), .AE_LEVEL(2)) u_c (
      .clk(clk), .rst_n(rst_n), .sclr(c_clr), .wrreq(c_wr), .data_in(c_din),
      .wrfull(c_full), .wr_almost_full(c_af), .wrusedw(c_wru), .rdreq(c_rd),
      .data_out(c_dout), .rdempty(c_empty), .rd_almost_empty(c_ae), .rdusedw(c_rdu),
      .overflow(c_ovf), .underflow(c_unf));

   typedef struct {
      logic        wr, rd, clr;
      logic [7:0]  din;
      logic [31:0] exp;
   } vec_t;

   int   n_checks = 0;
   int   n_errors = 0;
   vec_t vq[$];

   logic [31:0] a_act;
   assign a_act = {a_empty, a_full, a_rdu, a_wru, a_dout, a_ovf, a_unf, a_ae, a_af};

   // Expected A outputs for a given unit count (WI=1, RO=2, depth 16, AF 12, AE 2).
   function automatic logic [31:0] exp_a(int used, int dout, bit ovf, bit unf);
      return {used < 2, used == 16, 5'(used / 2), 5'(used), 16'(dout), ovf, unf,
              used <= 2, used >= 12};
   endfunction

   function automatic vec_t mk(bit wr, bit rd, bit clr, int din, int used, int dout,
                               bit ovf = 1'b0, bit unf = 1'b0);
      vec_t v;
      v.wr  = wr;
      v.rd  = rd;
      v.clr = clr;
      v.din = 8'(din);
      v.exp = exp_a(used, dout, ovf, unf);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b1;
      {a_clr, a_wr, a_rd, b_clr, b_wr, b_rd, c_clr, c_wr, c_rd} = '0;
      a_din = '0; b_din = '0; c_din = '0;
      #2 rst_n = 1'b0;
      #10;
      chk("a_reset", a_act, exp_a(0, 0, 1'b0, 1'b0));
      chk("b_reset", {10'd0, b_empty, b_full, b_rdu, b_wru, b_dout, b_ovf, b_unf, b_ae, b_af},
          {10'd0, 1'b1, 1'b0, 5'd0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
      chk("c_reset", {18'd0, c_empty, c_full, c_rdu, c_wru},
          {18'd0, 1'b1, 1'b0, 5'd0, 5'd0});
      rst_n = 1'b1;

      // ---- A: table-driven packing, odd byte, full/overflow, drain/underflow, flush ----
      vq.push_back(mk(1, 0, 0, 'h11, 1, 0));
      vq.push_back(mk(1, 0, 0, 'h22, 2, 0));
      vq.push_back(mk(1, 0, 0, 'h33, 3, 0));
      vq.push_back(mk(1, 0, 0, 'h44, 4, 0));
      vq.push_back(mk(0, 1, 0, 'h00, 2, 'h2211));
      vq.push_back(mk(0, 1, 0, 'h00, 0, 'h4433));
      vq.push_back(mk(0, 1, 0, 'h00, 0, 'h4433, 1'b0, 1'b1));
      vq.push_back(mk(0, 0, 0, 'h00, 0, 'h4433));
      vq.push_back(mk(1, 0, 0, 'h55, 1, 'h4433));
      vq.push_back(mk(0, 1, 0, 'h00, 1, 'h4433, 1'b0, 1'b1));
      vq.push_back(mk(1, 0, 0, 'h66, 2, 'h4433));
      vq.push_back(mk(0, 1, 0, 'h00, 0, 'h6655));
      for (int i = 0; i < 16; i++)
         vq.push_back(mk(1, 0, 0, 'hA0 + i, i + 1, 'h6655));
      vq.push_back(mk(1, 0, 0, 'hEE, 16, 'h6655, 1'b1, 1'b0));
      for (int k = 0; k < 8; k++)
         vq.push_back(mk(0, 1, 0, 'h00, 14 - 2 * k, ((('hA1 + 2 * k)) << 8) | ('hA0 + 2 * k)));
      vq.push_back(mk(0, 1, 0, 'h00, 0, 'hAFAE, 1'b0, 1'b1));
      vq.push_back(mk(1, 0, 0, 'h01, 1, 'hAFAE));
      vq.push_back(mk(1, 0, 0, 'h02, 2, 'hAFAE));
      vq.push_back(mk(1, 0, 0, 'h03, 3, 'hAFAE));
      vq.push_back(mk(1, 1, 1, 'h04, 0, 'hAFAE));
      vq.push_back(mk(1, 0, 0, 'h10, 1, 'hAFAE));
      vq.push_back(mk(1, 0, 0, 'h20, 2, 'hAFAE));
      vq.push_back(mk(0, 1, 0, 'h00, 0, 'h2010));

      step();
      for (int i = 0; i < vq.size(); i++) begin
         a_wr  = vq[i].wr;
         a_rd  = vq[i].rd;
         a_clr = vq[i].clr;
         a_din = vq[i].din;
         step();
         chk($sformatf("a_vec%0d", i), a_act, vq[i].exp);
      end
      a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0;

      // ---- B: 32 -> 8 show-ahead unpacking ----
      b_wr = 1'b1; b_din = 32'hA1B2C3D4;
      step();
      b_wr = 1'b0;
      chk("b_first", {13'd0, b_empty, b_rdu, b_wru, b_dout}, {13'd0, 1'b0, 5'd4, 5'd1, 8'hD4});
      b_rd = 1'b1;
      step();
      chk("b_rd1", {13'd0, b_empty, b_rdu, b_wru, b_dout}, {13'd0, 1'b0, 5'd3, 5'd0, 8'hC3});
      step();
      chk("b_rd2", {13'd0, b_empty, b_rdu, b_wru, b_dout}, {13'd0, 1'b0, 5'd2, 5'd0, 8'hB2});
      step();
      chk("b_rd3", {13'd0, b_empty, b_rdu, b_wru, b_dout}, {13'd0, 1'b0, 5'd1, 5'd0, 8'hA1});
      step();
      chk("b_rd4", {13'd0, b_empty, b_rdu, b_wru, b_dout}, {13'd0, 1'b1, 5'd0, 5'd0, 8'hA1});
      step();
      chk("b_unf", {22'd0, b_unf, b_empty, b_dout}, {22'd0, 1'b1, 1'b1, 8'hA1});
      b_rd = 1'b0;
      b_wr = 1'b1; b_din = 32'h05060708;
      step();
      b_wr = 1'b0;
      chk("b_second", {22'd0, b_unf, b_empty, b_dout}, {22'd0, 1'b0, 1'b0, 8'h08});

      // ---- C: 15 of 16 used, simultaneous read/write across pointer wrap ----
      for (int i = 0; i < 15; i++) begin
         c_wr = 1'b1; c_din = 8'(8'h30 + i);
         step();
      end
      c_wr = 1'b0;
      chk("c_fill", {25'd0, c_full, c_empty, c_wru}, {25'd0, 1'b0, 1'b0, 5'd15});
      for (int i = 0; i < 20; i++) begin
         c_wr = 1'b1; c_rd = 1'b1; c_din = 8'(8'h3F + i);
         step();
         chk($sformatf("c_conc%0d", i), {17'd0, c_dout, c_wru, c_ovf, c_unf},
             {17'd0, 8'(8'h30 + i), 5'd15, 1'b0, 1'b0});
      end
      c_wr = 1'b0;
      for (int i = 0; i < 15; i++) begin
         c_rd = 1'b1;
         step();
         chk($sformatf("c_drain%0d", i), {24'd0, c_dout}, {24'd0, 8'(8'h44 + i)});
      end
      c_rd = 1'b0;
      step();
      chk("c_empty", {29'd0, c_empty, c_unf, c_ovf}, {29'd0, 1'b1, 1'b0, 1'b0});

      // ---- A: async reset mid-transfer discards everything ----
      a_wr = 1'b1; a_din = 8'h77;
      step();
      a_din = 8'h88;
      step();
      chk("a_pre_rst", a_act, exp_a(2, 'h2010, 1'b0, 1'b0));
      a_din = 8'h99;
      #2 rst_n = 1'b0;
      #1;
      chk("a_arst", a_act, exp_a(0, 0, 1'b0, 1'b0));
      a_wr = 1'b0;
      rst_n = 1'b1;
      step();
      a_wr = 1'b1; a_din = 8'h99;
      step();
      a_din = 8'hAA;
      step();
      chk("a_post_wr", a_act, exp_a(2, 0, 1'b0, 1'b0));
      a_wr = 1'b0; a_rd = 1'b1;
      step();
      a_rd = 1'b0;
      chk("a_post_rd", a_act, exp_a(0, 'hAA99, 1'b0, 1'b0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
